mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the existing 8-to-1, 3-bit mux (mux_8to1) among 8 requesters.
- Drives the mux select `s` and signals which requester owns the shared output `f`.
- Grants bursts bounded by MAX_HOLD transfers, with back-to-back handover and no idle cycle.
- Sits between 8 producer channels and one downstream consumer with a valid/ready handshake.

---
 rtl/mux_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 27 ++
 rtl/mux_rr_arbiter.sv | 110 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM encoding and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority pick: first set request scanning from start, wrapping mod N.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [SEL_W-1:0] off;

  // Rotate so start lands at bit 0, take the lowest set bit, then undo the rotation.
  always_comb begin
    dbl = {req, req} >> start;
    rot = dbl[N-1:0];
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    found = |req;
    idx   = start + off;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner selection for a shared 8:1 mux with bounded bursts and
// zero-bubble handover between owners.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             ready,
  output logic [SEL_W-1:0] sel,
  output logic [N-1:0]     grant,
  output logic             valid,
  output logic [3:0]       hold_cnt
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_d;
  logic [N-1:0]     grant_d;
  logic             valid_d;
  logic [3:0]       hold_d;

  logic             owner_req_c;
  logic             xfer_c;
  logic             last_c;
  logic             release_c;
  logic [SEL_W-1:0] pick_start_c;
  logic             pick_found_c;
  logic [SEL_W-1:0] pick_idx_c;

  assign owner_req_c  = req[sel];
  assign xfer_c       = valid & ready & owner_req_c;
  assign last_c       = (hold_cnt == 4'(MAX_HOLD - 1));
  assign release_c    = ~owner_req_c | (xfer_c & last_c);
  // On release the scan starts just past the owner; its own bit stays in as last priority.
  assign pick_start_c = (state_q == GRANT) ? (sel + SEL_W'(1)) : ptr_q;

  rr_pick u_pick (
    .req   (req),
    .start (pick_start_c),
    .found (pick_found_c),
    .idx   (pick_idx_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_found_c) state_d = GRANT;
      GRANT:   if (release_c && !pick_found_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d   = sel;
    grant_d = grant;
    valid_d = valid;
    hold_d  = hold_cnt;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        sel_d   = pick_found_c ? pick_idx_c : '0;
        grant_d = pick_found_c ? onehot(pick_idx_c) : '0;
        valid_d = pick_found_c;
        hold_d  = '0;
      end
      GRANT: begin
        if (release_c) begin
          ptr_d   = sel + SEL_W'(1);
          sel_d   = pick_found_c ? pick_idx_c : '0;
          grant_d = pick_found_c ? onehot(pick_idx_c) : '0;
          valid_d = pick_found_c;
          hold_d  = '0;
        end else if (xfer_c) begin
          hold_d = hold_cnt + 4'd1;
        end
      end
      default: begin
        sel_d   = '0;
        grant_d = '0;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      sel      <= '0;
      grant    <= '0;
      valid    <= 1'b0;
      hold_cnt <= '0;
    end else begin
      ptr_q    <= ptr_d;
      sel      <= sel_d;
      grant    <= grant_d;
      valid    <= valid_d;
      hold_cnt <= hold_d;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with hand-computed expected owners and counts.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       ready;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       valid;
  logic [3:0] hold_cnt;

  int checks = 0;
  int errors = 0;

  mux_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .ready    (ready),
    .sel      (sel),
    .grant    (grant),
    .valid    (valid),
    .hold_cnt (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_owner(input string tag, input int o, input int h);
    logic [7:0] oh;
    oh = 8'h01 << o;
    check({tag, ".sel"},   32'(sel),      32'(o));
    check({tag, ".grant"}, 32'(grant),    32'(oh));
    check({tag, ".valid"}, 32'(valid),    32'd1);
    check({tag, ".hold"},  32'(hold_cnt), 32'(h));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".sel"},   32'(sel),      32'd0);
    check({tag, ".grant"}, 32'(grant),    32'd0);
    check({tag, ".valid"}, 32'(valid),    32'd0);
    check({tag, ".hold"},  32'(hold_cnt), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req   = 8'hFF;
    ready = 1'b1;

    // 1: reset held with every request active
    for (int i = 0; i < 3; i++) begin
      step();
      expect_idle("rst");
    end
    reset = 1'b0;
    step();
    expect_owner("first", 0, 0);

    // 2: full rotation, four transfers per owner, wrapping back to 0
    for (int o = 0; o < 9; o++) begin
      for (int k = 0; k < 4; k++) begin
        expect_owner("rot", o % 8, k);
        step();
      end
    end
    expect_owner("rot_end", 1, 0);

    // 3: lone requester 5 re-granted at the hold limit
    req = 8'h20;
    step();
    for (int i = 0; i < 8; i++) begin
      expect_owner("lone", 5, i % 4);
      step();
    end

    // 4: stall freezes owner 2, withdrawal hands over to 6
    req = 8'h04;
    step();
    expect_owner("own2", 2, 0);
    step();
    step();
    expect_owner("own2_h2", 2, 2);
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      expect_owner("stall", 2, 2);
    end
    req = 8'h40;
    step();
    expect_owner("wd6", 6, 0);

    // 5: owner 7 wraps to 0 and comes back to 7
    req   = 8'h80;
    ready = 1'b1;
    step();
    expect_owner("own7", 7, 0);
    req = 8'h81;
    step();
    step();
    step();
    expect_owner("own7_h3", 7, 3);
    step();
    expect_owner("wrap0", 0, 0);
    for (int i = 0; i < 4; i++) step();
    expect_owner("back7", 7, 0);

    // 6: mid-burst reset of owner 3 at hold_cnt 2
    req = 8'h08;
    step();
    expect_owner("own3", 3, 0);
    step();
    step();
    expect_owner("own3_h2", 3, 2);
    reset = 1'b1;
    req   = 8'h12;
    step();
    expect_idle("midrst");
    reset = 1'b0;
    step();
    expect_owner("post_rst", 1, 0);

    // no requests left: fall back to idle with cleared outputs
    req = 8'h00;
    step();
    expect_idle("to_idle");
    step();
    expect_idle("stay_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
